// File: rtl/booth_mult_scheduler_if.sv
// Request/response bundle for booth_mult_scheduler.
//
// Carries the two operand requester channels and the product response
// channel between the requesters/consumer and the shared Booth engine.
//
// Signals (N = operand width):
//   req0_valid/req0_ready, req0_a[N], req0_b[N]  requester 0 channel
//   req1_valid/req1_ready, req1_a[N], req1_b[N]  requester 1 channel
//   rsp_valid/rsp_ready, rsp_product[2N], rsp_id  product response channel
//
// Modports:
//   master  requesters and result consumer (testbench / surrounding logic)
//   slave   the scheduler itself
interface booth_mult_scheduler_if #(
    parameter int N = 32
);
    logic           req0_valid;
    logic           req0_ready;
    logic [N-1:0]   req0_a;
    logic [N-1:0]   req0_b;

    logic           req1_valid;
    logic           req1_ready;
    logic [N-1:0]   req1_a;
    logic [N-1:0]   req1_b;

    logic           rsp_valid;
    logic           rsp_ready;
    logic [2*N-1:0] rsp_product;
    logic           rsp_id;

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_product, rsp_id
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_product, rsp_id
    );
endinterface

// File: rtl/booth_mult_scheduler.sv
// booth_mult_scheduler
//
// Shares one iterative radix-2 Booth multiplier between two requesters.
// A granted request's operands are latched, then one Booth add/sub plus
// arithmetic shift right is performed per clock for N clocks. The signed
// 2N-bit product is returned on a valid/ready response port together with
// the ID of the requester that issued it.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset; aborts any job in flight
//   bus    slave modport of booth_mult_scheduler_if (request/response channels)
//   busy   out  high while a job is stepping or its product is waiting
//
// Parameter:
//   N      operand width in bits (two's complement, N >= 2)
//
// Configuration macro:
//   BOOTH_SCHED_RR_EN  when defined, contested grants alternate between the
//                      requesters (round-robin); when undefined, requester 0
//                      always wins a contest.
module booth_mult_scheduler #(
    parameter int N = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    booth_mult_scheduler_if.slave bus,
    output logic                  busy
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;

    // P holds {accumulator[N:0], multiplier[N-1:0], booth guard bit}.
    logic [2*N+1:0] p;
    logic [N:0]     m;
    logic [CW-1:0]  cnt;
    logic           id;

    logic           grant;
    logic           accept;
    logic [N-1:0]   sel_a;
    logic [N-1:0]   sel_b;
    logic [N:0]     acc_next;
    logic [2*N+1:0] p_step;

`ifdef BOOTH_SCHED_RR_EN
    logic           last_grant;
`endif

    // Arbitration: picks which requester would be served if the engine is idle.
    always_comb begin
        grant = 1'b0;
`ifdef BOOTH_SCHED_RR_EN
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
`else
        if (!bus.req0_valid && bus.req1_valid) begin
            grant = 1'b1;
        end
`endif
    end

    assign sel_a = grant ? bus.req1_a : bus.req0_a;
    assign sel_b = grant ? bus.req1_b : bus.req0_b;

    // State register; reset abandons any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs. Ready is only offered in IDLE, so
    // a new job cannot be taken until the cycle after the response leaves.
    always_comb begin
        state_next     = state;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp_valid  = 1'b0;
        busy           = 1'b0;
        accept         = 1'b0;
        case (state)
            IDLE: begin
                bus.req0_ready = bus.req0_valid && !grant;
                bus.req1_ready = bus.req1_valid && grant;
                accept         = bus.req0_ready || bus.req1_ready;
                if (accept) begin
                    state_next = STEP;
                end
            end
            STEP: begin
                busy = 1'b1;
                if (cnt == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy          = 1'b1;
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One Booth step: the pair {multiplier LSB, guard bit} selects +M, -M
    // or nothing. The N+1-bit accumulator absorbs b = -2^(N-1) exactly.
    always_comb begin
        case (p[1:0])
            2'b01:   acc_next = p[2*N+1:N+1] + m;
            2'b10:   acc_next = p[2*N+1:N+1] - m;
            default: acc_next = p[2*N+1:N+1];
        endcase
        p_step = {acc_next[N], acc_next, p[N:1]};
    end

    // Datapath registers: operands are captured on the handshake only, so
    // later changes on the request inputs cannot disturb the running job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p   <= '0;
            m   <= '0;
            cnt <= '0;
            id  <= 1'b0;
`ifdef BOOTH_SCHED_RR_EN
            last_grant <= 1'b1;
`endif
        end else if (accept) begin
            p   <= {{(N+1){1'b0}}, sel_a, 1'b0};
            m   <= {sel_b[N-1], sel_b};
            cnt <= CW'(N);
            id  <= grant;
`ifdef BOOTH_SCHED_RR_EN
            last_grant <= grant;
`endif
        end else if (state == STEP) begin
            p   <= p_step;
            cnt <= cnt - CW'(1);
        end
    end

    // Product and ID are presented only while the response is valid.
    assign bus.rsp_product = (state == DONE) ? p[2*N:1] : '0;
    assign bus.rsp_id      = (state == DONE) ? id : 1'b0;

endmodule

// File: tb/tb_booth_mult_scheduler.sv
// Testbench for booth_mult_scheduler.
//
// Drives the request channels through the interface master side and
// compares every product and ID against a signed-multiply reference and a
// simple arbitration model. Honours BOOTH_SCHED_RR_EN for expected grants.
module tb_booth_mult_scheduler;
    localparam int N = 32;

    logic clk;
    logic rst_n;
    logic busy;
    int   checks;
    int   errors;
    logic model_last;

    booth_mult_scheduler_if #(.N(N)) bus_if ();

    booth_mult_scheduler #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if),
        .busy  (busy)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference product: plain signed 64-bit multiplication.
    function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b);
        longint pa;
        longint pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return 64'(pa * pb);
    endfunction

    // Arbitration model: single valid wins; a contest goes to req0 or alternates.
    function automatic logic expected_grant(input logic v0, input logic v1);
        if (v0 && v1) begin
`ifdef BOOTH_SCHED_RR_EN
            return ~model_last;
`else
            return 1'b0;
`endif
        end
        return v1 && !v0;
    endfunction

    // Drives one requester channel.
    task automatic drive_req(input logic who, input logic v, input logic [31:0] a, input logic [31:0] b);
        if (who) begin
            bus_if.req1_valid = v;
            bus_if.req1_a     = a;
            bus_if.req1_b     = b;
        end else begin
            bus_if.req0_valid = v;
            bus_if.req0_a     = a;
            bus_if.req0_b     = b;
        end
    endtask

    // Holds a request until it is accepted; afterwards scrambles the operands.
    task automatic issue(input logic who, input logic [31:0] a, input logic [31:0] b, output logic ok);
        ok = 1'b0;
        drive_req(who, 1'b1, a, b);
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if ((who ? bus_if.req1_ready : bus_if.req0_ready) === 1'b1) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        drive_req(who, 1'b0, $urandom, $urandom);
    endtask

    // Counts edges from the handshake until rsp_valid shows up.
    task automatic wait_rsp(output logic got, output int edges);
        got   = 1'b0;
        edges = 0;
        while (!got && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus_if.rsp_valid === 1'b1) begin
                got = 1'b1;
            end
        end
    endtask

    task automatic consume();
        bus_if.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.rsp_ready = 1'b0;
    endtask

    task automatic applyStimulus(input logic who, input logic [31:0] a, input logic [31:0] b,
                                 input logic take, output logic ok, output logic got,
                                 output int edges, output logic [63:0] prod, output logic rid);
        issue(who, a, b, ok);
        got   = 1'b0;
        edges = 0;
        prod  = '0;
        rid   = 1'b0;
        if (ok) begin
            wait_rsp(got, edges);
            prod = bus_if.rsp_product;
            rid  = bus_if.rsp_id;
            if (got && take) begin
                consume();
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus_if.rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_rsp_valid: got %b expected 0", bus_if.rsp_valid);
        end
        checks++;
        if (bus_if.rsp_product !== 64'd0) begin
            errors++;
            $display("[TB] FAIL reset_product: got %h expected 0", bus_if.rsp_product);
        end
        checks++;
        if (bus_if.rsp_id !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_id: got %b expected 0", bus_if.rsp_id);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
        checks++;
        if (bus_if.req0_ready !== 1'b0 || bus_if.req1_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b%b expected 00", bus_if.req0_ready, bus_if.req1_ready);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [31:0] da [4];
        logic [31:0] db [4];
        logic        dw [4];
        logic        ok;
        logic        got;
        int          edges;
        logic [63:0] prod;
        logic        rid;
        da = '{32'd3, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000};
        db = '{32'd5, 32'd3,         32'h8000_0000, 32'd1};
        dw = '{1'b0,  1'b1,          1'b0,          1'b1};
        for (int k = 0; k < 4; k++) begin
            applyStimulus(dw[k], da[k], db[k], 1'b1, ok, got, edges, prod, rid);
            checks++;
            if (!(ok && got)) begin
                errors++;
                $display("[TB] FAIL directed_handshake[%0d]: got ok=%b rsp=%b expected 1 1", k, ok, got);
            end
            checks++;
            if (edges != N) begin
                errors++;
                $display("[TB] FAIL directed_latency[%0d]: got %0d expected %0d", k, edges, N);
            end
            checks++;
            if (prod !== ref_product(da[k], db[k])) begin
                errors++;
                $display("[TB] FAIL directed_product[%0d]: got %h expected %h", k, prod, ref_product(da[k], db[k]));
            end
            checks++;
            if (rid !== dw[k]) begin
                errors++;
                $display("[TB] FAIL directed_id[%0d]: got %b expected %b", k, rid, dw[k]);
            end
            checks++;
            if (bus_if.rsp_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL directed_rsp_drop[%0d]: got %b expected 0", k, bus_if.rsp_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic        who;
        logic        ok;
        logic        got;
        int          edges;
        logic [63:0] prod;
        logic        rid;
        for (int k = 0; k < 16; k++) begin
            a   = $urandom;
            b   = $urandom;
            who = 1'($urandom_range(0, 1));
            applyStimulus(who, a, b, 1'b1, ok, got, edges, prod, rid);
            checks++;
            if (!(ok && got) || prod !== ref_product(a, b)) begin
                errors++;
                $display("[TB] FAIL random_product[%0d]: got %h expected %h", k, prod, ref_product(a, b));
            end
            checks++;
            if (rid !== who) begin
                errors++;
                $display("[TB] FAIL random_id[%0d]: got %b expected %b", k, rid, who);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a0, b0, a1, b1, ca, cb;
        logic        who;
        logic        exp_who;
        logic        ok;
        logic        got;
        int          edges;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        model_last = 1'b1;
        exp_who    = 1'b0;
        a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
        ca = '0; cb = '0;
        drive_req(1'b0, 1'b1, a0, b0);
        drive_req(1'b1, 1'b1, a1, b1);
        for (int j = 0; j < 4; j++) begin
            ok = 1'b0;
            for (int i = 0; i < 200 && !ok; i++) begin
                @(negedge clk);
                if (bus_if.req0_ready === 1'b1 || bus_if.req1_ready === 1'b1) begin
                    checks++;
                    if (bus_if.req0_ready === 1'b1 && bus_if.req1_ready === 1'b1) begin
                        errors++;
                        $display("[TB] FAIL b2b_both_ready[%0d]: got 11 expected one-hot", j);
                    end
                    who     = bus_if.req1_ready;
                    exp_who = expected_grant(1'b1, 1'b1);
                    checks++;
                    if (who !== exp_who) begin
                        errors++;
                        $display("[TB] FAIL b2b_grant[%0d]: got %b expected %b", j, who, exp_who);
                    end
                    ca = who ? a1 : a0;
                    cb = who ? b1 : b0;
                    @(posedge clk);
                    #1;
                    ok         = 1'b1;
                    model_last = who;
                    if (who) begin
                        a1 = $urandom; b1 = $urandom;
                        drive_req(1'b1, 1'b1, a1, b1);
                    end else begin
                        a0 = $urandom; b0 = $urandom;
                        drive_req(1'b0, 1'b1, a0, b0);
                    end
                end
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL b2b_accept[%0d]: got timeout expected handshake", j);
            end else begin
                wait_rsp(got, edges);
                checks++;
                if (!got || bus_if.rsp_product !== ref_product(ca, cb)) begin
                    errors++;
                    $display("[TB] FAIL b2b_product[%0d]: got %h expected %h", j, bus_if.rsp_product, ref_product(ca, cb));
                end
                checks++;
                if (bus_if.rsp_id !== exp_who) begin
                    errors++;
                    $display("[TB] FAIL b2b_id[%0d]: got %b expected %b", j, bus_if.rsp_id, exp_who);
                end
                if (got) begin
                    consume();
                end
            end
        end
        drive_req(1'b0, 1'b0, '0, '0);
        drive_req(1'b1, 1'b0, '0, '0);
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, c, d;
        logic        ok;
        logic        got;
        int          edges;
        logic [63:0] prod;
        logic        rid;
        logic [63:0] exp;
        a = $urandom; b = $urandom; c = $urandom; d = $urandom;
        exp = ref_product(a, b);
        applyStimulus(1'b0, a, b, 1'b0, ok, got, edges, prod, rid);
        checks++;
        if (!(ok && got)) begin
            errors++;
            $display("[TB] FAIL bp_first_job: got ok=%b rsp=%b expected 1 1", ok, got);
        end
        drive_req(1'b1, 1'b1, c, d);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (bus_if.rsp_valid !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL bp_hold_valid[%0d]: got %b/%b expected 1/1", i, bus_if.rsp_valid, busy);
            end
            checks++;
            if (bus_if.rsp_product !== exp) begin
                errors++;
                $display("[TB] FAIL bp_hold_product[%0d]: got %h expected %h", i, bus_if.rsp_product, exp);
            end
            checks++;
            if (bus_if.rsp_id !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold_id[%0d]: got %b expected 0", i, bus_if.rsp_id);
            end
            checks++;
            if (bus_if.req0_ready !== 1'b0 || bus_if.req1_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold_ready[%0d]: got %b%b expected 00", i, bus_if.req0_ready, bus_if.req1_ready);
            end
        end
        bus_if.rsp_ready = 1'b1;
        #1;
        checks++;
        if (bus_if.req1_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_release_early_ready: got %b expected 0", bus_if.req1_ready);
        end
        @(posedge clk);
        #1;
        bus_if.rsp_ready = 1'b0;
        checks++;
        if (bus_if.rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_release_valid: got %b expected 0", bus_if.rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (bus_if.req1_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_accept_after_release: got %b expected 1", bus_if.req1_ready);
        end
        @(posedge clk);
        #1;
        drive_req(1'b1, 1'b0, $urandom, $urandom);
        wait_rsp(got, edges);
        checks++;
        if (!got || bus_if.rsp_product !== ref_product(c, d) || bus_if.rsp_id !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_second_job: got %h id %b expected %h id 1", bus_if.rsp_product, bus_if.rsp_id, ref_product(c, d));
        end
        if (got) begin
            consume();
        end
    endtask

    task automatic test_reset_mid();
        logic        ok;
        logic        got;
        int          edges;
        logic [63:0] prod;
        logic        rid;
        logic        stale;
        issue(1'b0, $urandom, $urandom, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL rstmid_accept: got timeout expected handshake");
        end
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_if.rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_async: got valid %b busy %b expected 0 0", bus_if.rsp_valid, busy);
        end
        checks++;
        if (bus_if.rsp_product !== 64'd0 || bus_if.rsp_id !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_outputs: got %h id %b expected 0 id 0", bus_if.rsp_product, bus_if.rsp_id);
        end
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        stale = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus_if.rsp_valid !== 1'b0 || busy !== 1'b0) begin
                stale = 1'b1;
            end
        end
        checks++;
        if (stale !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_stale: got %b expected 0", stale);
        end
        applyStimulus(1'b0, 32'd2, 32'd2, 1'b1, ok, got, edges, prod, rid);
        checks++;
        if (!(ok && got) || prod !== ref_product(32'd2, 32'd2) || edges != N) begin
            errors++;
            $display("[TB] FAIL rstmid_new_job: got %h after %0d edges expected %h after %0d", prod, edges, ref_product(32'd2, 32'd2), N);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        model_last = 1'b1;
        rst_n      = 1'b0;
        bus_if.rsp_ready = 1'b0;
        drive_req(1'b0, 1'b0, '0, '0);
        drive_req(1'b1, 1'b0, '0, '0);
        $display("[TB] starting booth_mult_scheduler bench");
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
